// File: rtl/counter_seq_pkg.sv
// Shared types and default sizes for the counter sequencer.
// The top level optionally adds an input prescaler when the macro
// COUNTER_SEQ_PRESCALE_EN is defined.
package counter_seq_pkg;

  localparam int DEFAULT_WIDTH    = 16;
  localparam int DEFAULT_RELOAD_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/counter_seq_datapath.sv
// Counter datapath: a WIDTH-bit count register with clear/increment/hold
// controls and a terminal-count compare against the latched period.
module counter_seq_datapath
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             inc_i,
  input  logic [WIDTH-1:0] period_i,
  output logic [WIDTH-1:0] count_o,
  output logic             at_term_o
);

  logic [WIDTH-1:0] count_q;

  // Count register: clear wins over increment, otherwise hold.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (inc_i) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count_o   = count_q;
  assign at_term_o = (count_q == period_i);

endmodule

// File: rtl/counter_sequencer.sv
// Programmable interval timer sequencer: FSM, reload tally and (optionally)
// the tick prescaler around the counter datapath. Defining
// COUNTER_SEQ_PRESCALE_EN adds the prescale input and an 8-bit divider.
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int RELOAD_W = DEFAULT_RELOAD_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                pause,
  input  logic                auto_reload,
  input  logic [WIDTH-1:0]    period,
`ifdef COUNTER_SEQ_PRESCALE_EN
  input  logic [7:0]          prescale,
`endif
  input  logic                tick_in,
  output logic [WIDTH-1:0]    count,
  output logic                busy,
  output logic                done,
  output logic [RELOAD_W-1:0] reload_cnt,
  output logic [1:0]          state
);

  state_t              state_q;
  logic                busy_q;
  logic                done_q;
  logic [RELOAD_W-1:0] reload_q;
  logic [WIDTH-1:0]    period_q;
  logic                mode_q;

  logic run_active;
  logic start_fresh;
  logic tick_ok;
  logic qual_tick;
  logic term_hit;
  logic cnt_clr;
  logic cnt_inc;
  logic at_term;

`ifdef COUNTER_SEQ_PRESCALE_EN
  logic [7:0] prescale_q;
  logic [7:0] div_q;

  assign tick_ok = tick_in && (div_q == prescale_q);

  // Prescale divider: clears with the count, frozen unless actively running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescale_q <= '0;
      div_q      <= '0;
    end else begin
      if (start_fresh) begin
        prescale_q <= prescale;
      end
      if (cnt_clr) begin
        div_q <= '0;
      end else if (run_active && tick_in) begin
        div_q <= (div_q == prescale_q) ? 8'd0 : div_q + 8'd1;
      end
    end
  end
`else
  assign tick_ok = tick_in;
`endif

  // Decode the prioritised inputs (stop > start > pause > tick) into
  // datapath controls.
  // NOTE: every signal is assigned on every path, so no latch is inferred.
  always_comb begin
    run_active  = (state_q == RUN) && !stop && !pause;
    start_fresh = start && !stop && ((state_q == IDLE) || (state_q == DONE));
    qual_tick   = run_active && tick_ok;
    term_hit    = qual_tick && at_term;
    cnt_clr     = stop || start_fresh || (term_hit && mode_q);
    cnt_inc     = qual_tick && !at_term;
  end

  counter_seq_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (cnt_clr),
    .inc_i     (cnt_inc),
    .period_i  (period_q),
    .count_o   (count),
    .at_term_o (at_term)
  );

  // Control FSM with registered busy/done/tally outputs and run latches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      reload_q <= '0;
      period_q <= '0;
      mode_q   <= 1'b0;
    end else begin
      done_q <= term_hit;
      case (state_q)
        IDLE, DONE: begin
          if (start_fresh) begin
            state_q  <= RUN;
            busy_q   <= 1'b1;
            period_q <= period;
            mode_q   <= auto_reload;
            reload_q <= '0;
          end else if (stop) begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          if (stop) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (pause) begin
            state_q <= PAUSE;
          end else if (term_hit) begin
            if (mode_q) begin
              if (reload_q != '1) begin
                reload_q <= reload_q + RELOAD_W'(1);
              end
            end else begin
              state_q <= DONE;
              busy_q  <= 1'b0;
            end
          end
        end
        PAUSE: begin
          if (stop) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (!pause) begin
            state_q <= RUN;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign reload_cnt = reload_q;
  assign state      = state_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench for counter_sequencer: stimulus pushes the expected
// post-edge output snapshot, a monitor pops and compares on the falling edge.
module tb_counter_sequencer;
  import counter_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, stop, pause, auto_reload, tick_in;
  logic [15:0] period;
  logic [15:0] count;
  logic        busy, done;
  logic [7:0]  reload_cnt;
  logic [1:0]  state;
`ifdef COUNTER_SEQ_PRESCALE_EN
  logic [7:0]  prescale;
`endif

  typedef struct {
    string       name;
    logic [1:0]  st;
    logic [15:0] cnt;
    logic        bsy;
    logic        dn;
    logic [7:0]  rl;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  counter_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .pause       (pause),
    .auto_reload (auto_reload),
    .period      (period),
`ifdef COUNTER_SEQ_PRESCALE_EN
    .prescale    (prescale),
`endif
    .tick_in     (tick_in),
    .count       (count),
    .busy        (busy),
    .done        (done),
    .reload_cnt  (reload_cnt),
    .state       (state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic s, input logic sp, input logic p, input logic ar,
                        input logic [15:0] per, input logic t);
    start       = s;
    stop        = sp;
    pause       = p;
    auto_reload = ar;
    period      = per;
    tick_in     = t;
  endtask

  task automatic expect_out(input string nm, input logic [1:0] st, input logic [15:0] c,
                            input logic b, input logic d, input logic [7:0] r);
    exp_t e;
    e.name = nm;
    e.st   = st;
    e.cnt  = c;
    e.bsy  = b;
    e.dn   = d;
    e.rl   = r;
    exp_q.push_back(e);
  endtask

  // One clock with the current inputs, then queue the expected outputs.
  task automatic cyc(input string nm, input logic [1:0] st, input logic [15:0] c,
                     input logic b, input logic d, input logic [7:0] r);
    @(posedge clk);
    #1;
    expect_out(nm, st, c, b, d, r);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare the queued snapshot against the DUT away from the edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.name, ".state"},      32'(state),      32'(e.st));
        check({e.name, ".count"},      32'(count),      32'(e.cnt));
        check({e.name, ".busy"},       32'(busy),       32'(e.bsy));
        check({e.name, ".done"},       32'(done),       32'(e.dn));
        check({e.name, ".reload_cnt"}, 32'(reload_cnt), 32'(e.rl));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    reset = 1'b1;
    set_in(0, 0, 0, 0, 16'd0, 0);
`ifdef COUNTER_SEQ_PRESCALE_EN
    prescale = 8'd0;
`endif
    cyc("reset", IDLE, 16'd0, 0, 0, 8'd0);
    reset = 1'b0;

    // One-shot, period 3, tick held high.
    set_in(1, 0, 0, 0, 16'd3, 1);
    cyc("os_start", RUN, 16'd0, 1, 0, 8'd0);
    start = 1'b0;
    cyc("os_c1", RUN, 16'd1, 1, 0, 8'd0);
    cyc("os_c2", RUN, 16'd2, 1, 0, 8'd0);
    cyc("os_c3", RUN, 16'd3, 1, 0, 8'd0);
    cyc("os_term", DONE, 16'd3, 0, 1, 8'd0);
    period = 16'd7;
    cyc("os_hold1", DONE, 16'd3, 0, 0, 8'd0);
    cyc("os_hold2", DONE, 16'd3, 0, 0, 8'd0);
    tick_in = 1'b0;
    stop    = 1'b1;
    cyc("os_stop", IDLE, 16'd0, 0, 0, 8'd0);
    stop = 1'b0;

    // Auto-reload, period 2, nine ticks.
    set_in(1, 0, 0, 1, 16'd2, 0);
    cyc("ar_start", RUN, 16'd0, 1, 0, 8'd0);
    start   = 1'b0;
    tick_in = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      cyc("ar_tick", RUN, 16'(k % 3), 1, (k % 3) == 0, 8'(k / 3));
    end
    tick_in = 1'b0;
    cyc("ar_idle", RUN, 16'd0, 1, 0, 8'd3);
    stop = 1'b1;
    cyc("ar_stop", IDLE, 16'd0, 0, 0, 8'd3);
    stop = 1'b0;

    // Pause / start-ignored / stop-over-start priority.
    set_in(1, 0, 0, 0, 16'd10, 0);
    cyc("ps_start", RUN, 16'd0, 1, 0, 8'd0);
    start   = 1'b0;
    tick_in = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      cyc("ps_count", RUN, 16'(k), 1, 0, 8'd0);
    end
    pause = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc("ps_hold", PAUSE, 16'd5, 1, 0, 8'd0);
    end
    pause = 1'b0;
    cyc("ps_release", RUN, 16'd5, 1, 0, 8'd0);
    cyc("ps_resume", RUN, 16'd6, 1, 0, 8'd0);
    start       = 1'b1;
    period      = 16'd1;
    auto_reload = 1'b1;
    cyc("ps_start_ign", RUN, 16'd7, 1, 0, 8'd0);
    stop = 1'b1;
    cyc("ps_stop_start", IDLE, 16'd0, 0, 0, 8'd0);
    set_in(0, 0, 0, 0, 16'd0, 0);
    cyc("ps_idle", IDLE, 16'd0, 0, 0, 8'd0);

    // period 0: done after the first tick; restart from DONE.
    set_in(1, 0, 0, 0, 16'd0, 0);
    cyc("p0_start", RUN, 16'd0, 1, 0, 8'd0);
    start   = 1'b0;
    tick_in = 1'b1;
    cyc("p0_term", DONE, 16'd0, 0, 1, 8'd0);
    cyc("p0_hold", DONE, 16'd0, 0, 0, 8'd0);

    // Reload tally saturation: period 0 auto-reload, 300 reloads.
    set_in(1, 0, 0, 1, 16'd0, 0);
    cyc("sat_start", RUN, 16'd0, 1, 0, 8'd0);
    start   = 1'b0;
    tick_in = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      cyc("sat_tick", RUN, 16'd0, 1, 1, (k < 255) ? 8'(k) : 8'hFF);
    end
    tick_in = 1'b0;
    cyc("sat_idle", RUN, 16'd0, 1, 0, 8'hFF);
    stop = 1'b1;
    cyc("sat_stop", IDLE, 16'd0, 0, 0, 8'hFF);
    stop = 1'b0;

    // Full-range one-shot: terminal at FFFF without wrapping.
    set_in(1, 0, 0, 0, 16'hFFFF, 0);
    cyc("max_start", RUN, 16'd0, 1, 0, 8'd0);
    start   = 1'b0;
    tick_in = 1'b1;
    for (int k = 1; k <= 65535; k++) begin
      if (k >= 65533 || (k % 16384) == 0) begin
        cyc("max_count", RUN, 16'(k), 1, 0, 8'd0);
      end else begin
        step();
      end
    end
    cyc("max_term", DONE, 16'hFFFF, 0, 1, 8'd0);
    cyc("max_hold", DONE, 16'hFFFF, 0, 0, 8'd0);
    tick_in = 1'b0;
    stop    = 1'b1;
    cyc("max_stop", IDLE, 16'd0, 0, 0, 8'd0);
    stop = 1'b0;

    // Asynchronous reset between edges in the middle of a run.
    set_in(1, 0, 0, 1, 16'd2, 0);
    cyc("rs_start", RUN, 16'd0, 1, 0, 8'd0);
    start   = 1'b0;
    tick_in = 1'b1;
    cyc("rs_c1", RUN, 16'd1, 1, 0, 8'd0);
    cyc("rs_c2", RUN, 16'd2, 1, 0, 8'd0);
    cyc("rs_reload", RUN, 16'd0, 1, 1, 8'd1);
    cyc("rs_c1b", RUN, 16'd1, 1, 0, 8'd1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rs_async.state",      32'(state),      32'(IDLE));
    check("rs_async.count",      32'(count),      32'd0);
    check("rs_async.busy",       32'(busy),       32'd0);
    check("rs_async.done",       32'(done),       32'd0);
    check("rs_async.reload_cnt", 32'(reload_cnt), 32'd0);
    step();
    reset = 1'b0;
    set_in(1, 0, 0, 0, 16'd2, 0);
    cyc("rs_restart", RUN, 16'd0, 1, 0, 8'd0);
    start   = 1'b0;
    tick_in = 1'b1;
    cyc("rs_r1", RUN, 16'd1, 1, 0, 8'd0);
    cyc("rs_r2", RUN, 16'd2, 1, 0, 8'd0);
    cyc("rs_rterm", DONE, 16'd2, 0, 1, 8'd0);
    tick_in = 1'b0;
    stop    = 1'b1;
    cyc("rs_stop", IDLE, 16'd0, 0, 0, 8'd0);
    stop = 1'b0;

`ifdef COUNTER_SEQ_PRESCALE_EN
    // Prescale 2, period 1: count steps every third pulse, done after six.
    set_in(1, 0, 0, 0, 16'd1, 0);
    prescale = 8'd2;
    cyc("pre_start", RUN, 16'd0, 1, 0, 8'd0);
    start   = 1'b0;
    tick_in = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      cyc("pre_tick", RUN, (k >= 3) ? 16'd1 : 16'd0, 1, 0, 8'd0);
    end
    cyc("pre_term", DONE, 16'd1, 0, 1, 8'd0);
    cyc("pre_hold", DONE, 16'd1, 0, 0, 8'd0);
    tick_in = 1'b0;
`endif

    // Let the monitor drain the scoreboard, bounded.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      @(negedge clk);
    end
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
